// File: rtl/pc_pkg.sv
// ----------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the program-counter unit.
//   pc_state_e : BOOT / RUN / HANDLER control states
//   pc_sel_e   : next-PC source selected by pc_next_sel
//   DEF_*      : default reset / exception vectors
// ----------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        HANDLER = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_J    = 3'd2,
        SEL_JR   = 3'd3,
        SEL_ERET = 3'd4,
        SEL_EXC  = 3'd5
    } pc_sel_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/pc_next_sel.sv
// ----------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC source selection for pc_unit.
// Inputs : i_state, i_exc_req, i_eret, i_jr, i_jump, i_branch_taken,
//          i_jr_target, i_jump_target, i_branch_target, i_current_pc, i_epc
// Outputs: o_sel        - winning source (priority EXC > ERET > JR > J > BR > SEQ)
//          o_target     - address of the winning source
//          o_misaligned - winning jr/jump/branch target has low bits set
//          o_pc_plus4   - i_current_pc + 4, wrapping
// ----------------------------------------------------------------------------
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH      = 32,
    parameter int unsigned     ALIGN_BITS = 2,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
    input  pc_state_e          i_state,
    input  logic               i_exc_req,
    input  logic               i_eret,
    input  logic               i_jr,
    input  logic               i_jump,
    input  logic               i_branch_taken,
    input  logic [WIDTH-1:0]   i_jr_target,
    input  logic [WIDTH-1:0]   i_jump_target,
    input  logic [WIDTH-1:0]   i_branch_target,
    input  logic [WIDTH-1:0]   i_current_pc,
    input  logic [WIDTH-1:0]   i_epc,
    output pc_sel_e            o_sel,
    output logic [WIDTH-1:0]   o_target,
    output logic               o_misaligned,
    output logic [WIDTH-1:0]   o_pc_plus4
);

    // Mask built by arithmetic so ALIGN_BITS = 0 needs no zero-width slice.
    localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

    logic w_checked;

    assign o_pc_plus4 = i_current_pc + WIDTH'(4);

    always_comb begin
        o_sel     = SEL_SEQ;
        o_target  = o_pc_plus4;
        w_checked = 1'b0;
        if (i_state == RUN && i_exc_req) begin
            o_sel    = SEL_EXC;
            o_target = EXC_VECTOR;
        end else if (i_state == HANDLER && i_eret) begin
            o_sel    = SEL_ERET;
            o_target = i_epc;
        end else if (i_jr) begin
            o_sel     = SEL_JR;
            o_target  = i_jr_target;
            w_checked = 1'b1;
        end else if (i_jump) begin
            o_sel     = SEL_J;
            o_target  = i_jump_target;
            w_checked = 1'b1;
        end else if (i_branch_taken) begin
            o_sel     = SEL_BR;
            o_target  = i_branch_target;
            w_checked = 1'b1;
        end
    end

    // Only control-transfer targets are checked; epc and pc+4 are trusted.
    assign o_misaligned = w_checked && ((o_target & ALIGN_MASK) != '0);

endmodule

// File: rtl/pc_unit.sv
// ----------------------------------------------------------------------------
// pc_unit
// Program counter with branch/jump/jr/exception/eret redirection, stall and
// fetch back-pressure handling, EPC capture, alignment checking and a
// fetched-instruction counter.
// Inputs : clk, reset (async, active-high), i_stall, i_fetch_ready,
//          i_branch_taken/i_branch_target, i_jump/i_jump_target,
//          i_jr/i_jr_target, i_exc_req, i_eret
// Outputs: o_current_pc, o_pc_plus4, o_fetch_valid, o_epc, o_in_handler,
//          o_addr_err (one-cycle pulse), o_inst_count
// ----------------------------------------------------------------------------
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int unsigned      ALIGN_BITS   = 2,
    parameter int unsigned      CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_stall,
    input  logic                 i_fetch_ready,
    input  logic                 i_branch_taken,
    input  logic [WIDTH-1:0]     i_branch_target,
    input  logic                 i_jump,
    input  logic [WIDTH-1:0]     i_jump_target,
    input  logic                 i_jr,
    input  logic [WIDTH-1:0]     i_jr_target,
    input  logic                 i_exc_req,
    input  logic                 i_eret,
    output logic [WIDTH-1:0]     o_current_pc,
    output logic [WIDTH-1:0]     o_pc_plus4,
    output logic                 o_fetch_valid,
    output logic [WIDTH-1:0]     o_epc,
    output logic                 o_in_handler,
    output logic                 o_addr_err,
    output logic [CNT_WIDTH-1:0] o_inst_count
);

    pc_state_e            r_state, w_state_d;
    logic [WIDTH-1:0]     r_pc, w_pc_d;
    logic [WIDTH-1:0]     r_epc, w_epc_d;
    logic                 r_addr_err, w_addr_err_d;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_d;

    pc_sel_e              w_sel;
    logic [WIDTH-1:0]     w_target;
    logic                 w_misaligned;
    logic                 w_advance;

    pc_next_sel #(
        .WIDTH      (WIDTH),
        .ALIGN_BITS (ALIGN_BITS),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .i_state         (r_state),
        .i_exc_req       (i_exc_req),
        .i_eret          (i_eret),
        .i_jr            (i_jr),
        .i_jump          (i_jump),
        .i_branch_taken  (i_branch_taken),
        .i_jr_target     (i_jr_target),
        .i_jump_target   (i_jump_target),
        .i_branch_target (i_branch_target),
        .i_current_pc    (r_pc),
        .i_epc           (r_epc),
        .o_sel           (w_sel),
        .o_target        (w_target),
        .o_misaligned    (w_misaligned),
        .o_pc_plus4      (o_pc_plus4)
    );

    assign o_fetch_valid = (r_state != BOOT);
    assign w_advance     = o_fetch_valid && i_fetch_ready && !i_stall;

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_epc_d      = r_epc;
        w_addr_err_d = 1'b0;
        w_cnt_d      = r_cnt;

        unique case (r_state)
            BOOT: begin
                w_state_d = RUN;
            end
            RUN: begin
                // Exception requests bypass stall and back-pressure.
                if (w_sel == SEL_EXC) begin
                    w_epc_d   = r_pc;
                    w_pc_d    = EXC_VECTOR;
                    w_state_d = HANDLER;
                end else if (w_advance) begin
                    if (w_misaligned) begin
                        w_addr_err_d = 1'b1;
                        w_epc_d      = r_pc;
                        w_pc_d       = EXC_VECTOR;
                        w_state_d    = HANDLER;
                    end else begin
                        w_pc_d = w_target;
                    end
                end
            end
            HANDLER: begin
                if (w_advance) begin
                    if (w_misaligned) begin
                        // No nesting: restart the handler, keep the original epc.
                        w_addr_err_d = 1'b1;
                        w_pc_d       = EXC_VECTOR;
                    end else begin
                        w_pc_d = w_target;
                        if (w_sel == SEL_ERET) begin
                            w_state_d = RUN;
                        end
                    end
                end
            end
            default: begin
                w_state_d = BOOT;
            end
        endcase

        if (w_advance) begin
            w_cnt_d = r_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VECTOR;
            r_epc      <= '0;
            r_addr_err <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_epc      <= w_epc_d;
            r_addr_err <= w_addr_err_d;
            r_cnt      <= w_cnt_d;
        end
    end

    assign o_current_pc = r_pc;
    assign o_epc        = r_epc;
    assign o_in_handler = (r_state == HANDLER);
    assign o_addr_err   = r_addr_err;
    assign o_inst_count = r_cnt;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    localparam logic [31:0] EXC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, fetch_ready, branch_taken, jump, jr, exc_req, eret;
    logic [31:0] branch_target, jump_target, jr_target;
    logic [31:0] current_pc, pc_plus4, epc, inst_count;
    logic        fetch_valid, in_handler, addr_err;

    always #5 clk = ~clk;

    pc_unit #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (EXC),
        .ALIGN_BITS   (2),
        .CNT_WIDTH    (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_stall         (stall),
        .i_fetch_ready   (fetch_ready),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .i_jr            (jr),
        .i_jr_target     (jr_target),
        .i_exc_req       (exc_req),
        .i_eret          (eret),
        .o_current_pc    (current_pc),
        .o_pc_plus4      (pc_plus4),
        .o_fetch_valid   (fetch_valid),
        .o_epc           (epc),
        .o_in_handler    (in_handler),
        .o_addr_err      (addr_err),
        .o_inst_count    (inst_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] epc;
        logic        inh;
        logic        aerr;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    // Reference model state: 0 = boot, 1 = run, 2 = handler
    int          m_state;
    logic [31:0] m_pc, m_epc, m_cnt;
    logic        m_aerr;

    task automatic model_reset();
        m_state = 0;
        m_pc    = 32'h0;
        m_epc   = 32'h0;
        m_cnt   = 32'h0;
        m_aerr  = 1'b0;
        sb.delete();
    endtask

    // Advance the model by one edge using current inputs, queue the expectation.
    task automatic model_step();
        logic        adv;
        logic [31:0] tgt;
        logic        chk;
        exp_t        e;
        adv    = (m_state != 0) && fetch_ready && !stall;
        m_aerr = 1'b0;
        if (adv) m_cnt = m_cnt + 1;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1 && exc_req) begin
            m_epc   = m_pc;
            m_pc    = EXC;
            m_state = 2;
        end else if (adv) begin
            if (m_state == 2 && eret) begin
                m_pc    = m_epc;
                m_state = 1;
            end else begin
                chk = jr || jump || branch_taken;
                tgt = jr ? jr_target : jump ? jump_target : branch_taken ? branch_target : m_pc + 4;
                if (chk && tgt[1:0] != 2'b00) begin
                    m_aerr = 1'b1;
                    if (m_state == 1) begin
                        m_epc   = m_pc;
                        m_state = 2;
                    end
                    m_pc = EXC;
                end else begin
                    m_pc = tgt;
                end
            end
        end
        e.pc    = m_pc;
        e.valid = (m_state != 0);
        e.epc   = m_epc;
        e.inh   = (m_state == 2);
        e.aerr  = m_aerr;
        e.cnt   = m_cnt;
        sb.push_back(e);
    endtask

    // Inputs are already applied; push expectation, clock, then compare.
    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("pc",       current_pc,          e.pc);
            check("pc_plus4", pc_plus4,            e.pc + 32'd4);
            check("valid",    {31'd0, fetch_valid}, {31'd0, e.valid});
            check("epc",      epc,                 e.epc);
            check("in_hdl",   {31'd0, in_handler},  {31'd0, e.inh});
            check("addr_err", {31'd0, addr_err},    {31'd0, e.aerr});
            check("count",    inst_count,          e.cnt);
        end
    endtask

    task automatic clear_ctl();
        branch_taken = 0; jump = 0; jr = 0; exc_req = 0; eret = 0; stall = 0;
        fetch_ready  = 1;
    endtask

    task automatic goto(input logic [31:0] a);
        jump = 1; jump_target = a;
        cycle();
        jump = 0;
    endtask

    initial begin
        reset = 1;
        clear_ctl();
        branch_target = 0; jump_target = 0; jr_target = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc",    current_pc, 32'h0);
        check("rst_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_cnt",   inst_count, 32'h0);
        @(negedge clk);
        reset = 0;

        // Boot cycle, then sequential 0,4,8
        cycle();
        check("boot_pc", current_pc, 32'h0);
        cycle();
        cycle();
        check("seq_pc",  current_pc, 32'h8);
        check("seq_cnt", inst_count, 32'd2);

        // Jump beats branch; jr beats both
        branch_taken = 1; branch_target = 32'h40; jump = 1; jump_target = 32'h100;
        cycle();
        check("j_over_br", current_pc, 32'h100);
        jr = 1; jr_target = 32'h200;
        cycle();
        check("jr_over_j", current_pc, 32'h200);
        clear_ctl();

        // Stall holds; exception overrides stall
        goto(32'h10);
        stall = 1;
        cycle();
        cycle();
        check("stall_pc", current_pc, 32'h10);
        exc_req = 1;
        cycle();
        check("exc_pc",  current_pc, EXC);
        check("exc_epc", epc, 32'h10);
        stall = 0;

        // Nested exc_req ignored, then eret returns
        cycle();
        check("nest_pc", current_pc, EXC + 32'd4);
        exc_req = 0;
        cycle();
        eret = 1;
        cycle();
        check("eret_pc", current_pc, 32'h10);
        check("eret_ih", {31'd0, in_handler}, 32'd0);
        // eret in RUN ignored
        cycle();
        check("eret_run", current_pc, 32'h14);
        eret = 0;

        // Misaligned jr in RUN
        goto(32'h20);
        jr = 1; jr_target = 32'h102;
        cycle();
        check("mis_aerr", {31'd0, addr_err}, 32'd1);
        check("mis_epc",  epc, 32'h20);
        jr = 0;
        cycle();
        // Misaligned branch in HANDLER keeps epc
        branch_taken = 1; branch_target = 32'h41;
        cycle();
        branch_taken = 0;
        cycle();
        cycle();
        check("hdl_pc", current_pc, EXC + 32'd8);

        // Async reset mid-handler
        #3;
        reset = 1;
        #1;
        check("arst_pc",  current_pc, 32'h0);
        check("arst_epc", epc, 32'h0);
        check("arst_ih",  {31'd0, in_handler}, 32'd0);
        check("arst_cnt", inst_count, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 0;
        cycle();

        // Back-pressure holds PC and count
        fetch_ready = 0;
        cycle();
        cycle();
        check("bp_pc",  current_pc, 32'h0);
        check("bp_cnt", inst_count, 32'h0);
        fetch_ready = 1;

        // Wrap at top of address space
        goto(32'hFFFF_FFFC);
        check("wrap_p4", pc_plus4, 32'h0);
        cycle();
        check("wrap_pc", current_pc, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            stall         = ($urandom_range(0, 5) == 0);
            fetch_ready   = ($urandom_range(0, 5) != 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 5) == 0);
            jr            = ($urandom_range(0, 7) == 0);
            exc_req       = ($urandom_range(0, 9) == 0);
            eret          = ($urandom_range(0, 5) == 0);
            branch_target = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 9) == 0);
            jump_target   = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 9) == 0);
            jr_target     = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the MIPS core and the next generation of the basic PC register. It selects the next fetch address from sequential, branch, jump, jump-register, exception and exception-return sources. It also holds under stall or instruction-memory back-pressure, captures EPC on exceptions, checks target alignment, and counts fetched instructions. It sits between the control/branch logic and instruction memory.

Parameters:
WIDTH, 32, address width in bits (>= 8)
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h8000_0180, exception handler entry address
ALIGN_BITS, 2, low address bits that must be zero (word alignment)
CNT_WIDTH, 32, width of the fetched-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
stall  in  1  pipeline stall; holds PC while high
fetch_ready  in  1  instruction memory accepts current_pc this cycle
branch_taken  in  1  take branch_target
branch_target  in  WIDTH  branch destination
jump  in  1  take jump_target (j/jal)
jump_target  in  WIDTH  jump destination
jr  in  1  take jr_target (jr/jalr)
jr_target  in  WIDTH  register-indirect destination
exc_req  in  1  external exception request (overflow, syscall, illegal op)
eret  in  1  return from exception handler
current_pc  out  WIDTH  address being fetched
pc_plus4  out  WIDTH  current_pc + 4, combinational, wraps modulo 2^WIDTH
fetch_valid  out  1  current_pc is a valid fetch request
epc  out  WIDTH  saved exception PC
in_handler  out  1  high while executing the exception handler
addr_err  out  1  one-cycle pulse: selected target was misaligned
inst_count  out  CNT_WIDTH  number of accepted fetches

Behaviour:
- Reset (async, any state, mid-operation included): current_pc=RESET_VECTOR, epc=0, state=BOOT, fetch_valid=0, in_handler=0, addr_err=0, inst_count=0.
- States: BOOT, RUN, HANDLER. fetch_valid = (state != BOOT).
- BOOT: lasts exactly one cycle after reset deasserts. PC holds. Next state is RUN.
- advance = fetch_valid & fetch_ready & ~stall. All PC updates except exceptions require advance=1. Upstream holds branch, jump and jr requests stable until advance.
- Priority when advancing: exc_req (RUN only) > eret (HANDLER only) > jr > jump > branch_taken > sequential (pc_plus4).
- exc_req in RUN takes effect even when advance=0 (overrides stall and fetch_ready): epc<=current_pc, current_pc<=EXC_VECTOR, state<=HANDLER, in_handler<=1.
- exc_req in HANDLER is ignored (no nesting).
- eret in HANDLER with advance=1: current_pc<=epc, state<=RUN, in_handler<=0. eret in RUN is ignored; PC follows lower-priority sources.
- Misaligned target: if the selected jr, jump or branch target has any of the low ALIGN_BITS set, the target is discarded and addr_err pulses for one cycle.
  - In RUN: behaves as an exception with epc<=current_pc.
  - In HANDLER: current_pc<=EXC_VECTOR, epc unchanged.
- The eret target (epc) is never checked for alignment.
- inst_count increments by 1 on every advance and wraps to 0 at overflow. It does not increment in the cycle an exception is taken without advance.
- Latency: a redirect is visible on current_pc one clock after the accepting edge.
- PC arithmetic is unsigned modulo 2^WIDTH. At all-ones minus 3, the sequential next PC is 0.

Decomposition:
- Package pc_pkg: state enum (BOOT/RUN/HANDLER), source-select encoding (SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_ERET, SEL_EXC), default vector constants.
- One combinational sub-module, pc_next_sel: computes the priority mux, the selected target and the misalignment flag. pc_unit holds the state register, PC, EPC and counter.

Test Plan:
- Reset, then release with fetch_ready=1 -> cycle 1: current_pc=0, fetch_valid=0; cycle 2: fetch_valid=1; then 0,4,8; inst_count=2 after two advances.
- branch_taken=1 and jump=1 together, branch_target=0x40, jump_target=0x100, at PC=0x8 -> next PC=0x100. With jr=1, jr_target=0x200 also asserted -> 0x200.
- stall=1 for 3 cycles at PC=0x10 -> PC holds 0x10 and inst_count holds. exc_req pulses during the stall -> PC=0x80000180, epc=0x10, in_handler=1.
- In HANDLER, exc_req -> ignored, PC sequential from 0x80000180. Then eret -> PC=0x10, in_handler=0.
- jr_target=0x102 in RUN at PC=0x20 -> addr_err pulse, PC=0x80000180, epc=0x20.
- Async reset asserted mid-HANDLER at PC=0x80000188 -> immediate PC=0, epc=0, in_handler=0, inst_count=0. Also: fetch_ready=0 holds PC; PC=0xFFFFFFFC sequential -> wraps to 0x0.
